// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, registered carry.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // single full-adder cell
    logic fa_s, fa_c;
    assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        c_d      = c_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d      = fa_c;
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // result registers load only here, so they stay frozen outside this edge
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    co_d    = fa_c;
                    ovf_d   = c_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases then random ops against a+b+cin.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, busy;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold = cycles of out_ready low in DONE, poke = drive an
    // ignored request during the hold.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input int hold, input bit poke);
        logic [W:0]   ref_full;
        logic         ref_ovf;
        logic [W-1:0] held_sum;
        logic         held_co;
        int lat, bcnt;
        ref_full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        ref_ovf  = (ta[W-1] == tb_[W-1]) && (ref_full[W-1] != ta[W-1]);
        chk("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; carry_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        chk("latency", lat, W);
        chk("busy_cycles", bcnt, W);
        chk("sum", sum, ref_full[W-1:0]);
        chk("carry_out", carry_out, ref_full[W]);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, ref_ovf);
`endif
        held_sum = sum; held_co = carry_out;
        if (poke) begin
            a = 8'h01; b = 8'h00; in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, held_sum);
            chk("hold_co", carry_out, held_co);
        end
        in_valid = 1'b0; a = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        step();

        do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 5, 1'b1);

        // reset on the 4th RUN cycle abandons the op
        a = 8'hAA; b = 8'h55; carry_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        begin
            int seen = 0;
            out_ready = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (out_valid) seen++;
                step();
            end
            out_ready = 1'b0;
            chk("abandoned_result", seen, 0);
        end
        do_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one single-bit full-adder cell (a + b + carry_in -> sum, carry_out) plus a registered carry.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds the cell one bit per clock, LSB first, and collects the sum bits in a shift register.
- Returns the WIDTH-bit sum and final carry through a second valid/ready handshake. This is the sequencing stage that drives the full-adder cell and consumes its outputs.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present on a, b, carry_in
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  initial carry
- out_valid  output  1  sum/carry_out valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits [WIDTH-1:0]
- carry_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high while state is RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; carry_out=0; internal carry, counter and shift registers = 0.
- rst takes priority over all other inputs.
- Reset mid-operation: asserting rst in RUN or DONE abandons the operation. No partial result is presented and the result is never reported later.

States:
- IDLE: in_ready=1.
  - On in_valid&&in_ready at an edge: load a_sh<=a, b_sh<=b, c<=carry_in, cnt<=0, go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN: in_ready=0, busy=1. Each cycle:
  - s = a_sh[0]^b_sh[0]^c
  - c <= majority(a_sh[0], b_sh[0], c)
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}
  - a_sh and b_sh shift right by 1
  - cnt <= cnt+1
  - At the edge where cnt==WIDTH-1: go to DONE.
- DONE: out_valid=1; sum=sum_sh; carry_out=c.
  - Outputs stay stable until out_valid&&out_ready; then go to IDLE and out_valid=0 next cycle.
  - With out_ready low, the block holds indefinitely.

Timing and handshake rules:
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, output handshake, IDLE).
- in_valid during RUN/DONE is ignored (in_ready=0). Upstream must hold its operands until accepted.
- sum/carry_out change only on the RUN->DONE transition. Their values outside DONE are don't-care for checking but must not be X after reset.
- Arithmetic is unsigned modulo 2^WIDTH; carry_out is the 2^WIDTH bit. The result equals a+b+carry_in for all inputs, including all-ones + all-ones + 1 (sum=all-ones, carry_out=1).
- cnt width: $clog2(WIDTH)+1 bits, no wrap inside RUN.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - Block also registers the carry into bit WIDTH-1 during the final RUN cycle.
  - In DONE, ovf = carry_into_msb ^ carry_out (two's-complement signed overflow); held with sum.
- Undefined: port ovf and its register are absent; all other behaviour identical.

Test Plan:
- WIDTH=8, rst for 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0.
- a=8'h35, b=8'h4A, carry_in=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=8'h7F, carry_out=0; busy high 8 cycles.
- a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1. With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01, carry_in=0 -> sum=8'h80, ovf=1.
- out_ready=0 for 5 cycles after out_valid -> sum/carry_out stable, in_ready=0. New in_valid with a=8'h01 is ignored. After out_ready=1, one handshake, then in_ready=1.
- rst asserted on 4th RUN cycle of a=8'hAA, b=8'h55 -> next cycle IDLE, out_valid never asserts for that operation. Next op a=8'h10, b=8'h20 -> sum=8'h30.
- 200 back-to-back random ops (a, b, carry_in random, out_ready random) -> every result matches {carry_out,sum} = a+b+carry_in; no lost or duplicated results.
